// File: rtl/fast_kp_reader_if.sv
// Keypoint bus between the FAST keypoint source, the reader and the
// descriptor stage.
//   Write side : wren_XYO_fast, num_fast, XYO_fast, frame_end (into reader)
//   Read side  : kp_valid/kp_ready handshake with kp_x, kp_y, kp_o, kp_idx,
//                kp_last (out of reader, kp_ready into reader)
//   Status     : rd_done, kp_count, busy, ovf (out of reader)
// The reader connects through the slave modport. The source/sink side
// (a testbench or surrounding glue) connects through the master modport.
interface fast_kp_reader_if #(
    parameter int ADDR_W = 10,
    parameter int NUM_W  = 14,
    parameter int XYO_W  = 22
);
    logic              wren_XYO_fast;
    logic [NUM_W-1:0]  num_fast;
    logic [XYO_W-1:0]  XYO_fast;
    logic              frame_end;

    logic              kp_valid;
    logic              kp_ready;
    logic [9:0]        kp_x;
    logic [9:0]        kp_y;
    logic [1:0]        kp_o;
    logic [ADDR_W-1:0] kp_idx;
    logic              kp_last;

    logic              rd_done;
    logic [ADDR_W:0]   kp_count;
    logic              busy;
    logic              ovf;

    modport slave (
        input  wren_XYO_fast, num_fast, XYO_fast, frame_end, kp_ready,
        output kp_valid, kp_x, kp_y, kp_o, kp_idx, kp_last,
               rd_done, kp_count, busy, ovf
    );

    modport master (
        output wren_XYO_fast, num_fast, XYO_fast, frame_end, kp_ready,
        input  kp_valid, kp_x, kp_y, kp_o, kp_idx, kp_last,
               rd_done, kp_count, busy, ovf
    );
endinterface

// File: rtl/fast_kp_reader.sv
// fast_kp_reader: collects one frame of FAST keypoints into a synchronous
// read RAM, then, on frame_end, streams them in index order over a
// valid/ready handshake.
// Ports:
//   clk    : system clock, posedge
//   rst_n  : asynchronous active-low reset
//   kp_if  : fast_kp_reader_if.slave (write strobe/index/data, frame_end,
//            kp_* stream with kp_ready, rd_done, kp_count, busy, ovf)
module fast_kp_reader #(
    parameter int ADDR_W = 10,
    parameter int NUM_W  = 14,
    parameter int XYO_W  = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    fast_kp_reader_if.slave   kp_if
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, FETCH, SHOW, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   kp_count_q, kp_count_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W-1:0] kp_idx_q, kp_idx_d;
    logic              kp_last_q, kp_last_d;

    logic [XYO_W-1:0]  mem [DEPTH];
    logic [XYO_W-1:0]  ram_q;

    logic              out_of_range;
    logic              wr_ok;
    logic              rd_en;
    logic [ADDR_W:0]   num_plus1;
    logic [ADDR_W:0]   wr_cnt_upd;

    // Any set bit above the address range means the index cannot fit.
    assign out_of_range = |kp_if.num_fast[NUM_W-1:ADDR_W];
    assign wr_ok        = kp_if.wren_XYO_fast && !out_of_range && (state_q == IDLE);
    assign num_plus1    = {1'b0, kp_if.num_fast[ADDR_W-1:0]} + (ADDR_W+1)'(1);
    // High-water mark; num_plus1 never exceeds DEPTH, so this saturates.
    assign wr_cnt_upd   = (wr_ok && (num_plus1 > wr_cnt_q)) ? num_plus1 : wr_cnt_q;

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        kp_count_d = kp_count_q;
        wr_cnt_d   = wr_cnt_q;
        kp_idx_d   = kp_idx_q;
        kp_last_d  = kp_last_q;
        rd_en      = 1'b0;
        ovf_d      = ovf_q | (kp_if.wren_XYO_fast && (out_of_range || (state_q != IDLE)));

        case (state_q)
            IDLE: begin
                wr_cnt_d = wr_cnt_upd;
                if (kp_if.frame_end) begin
                    // A write in the same cycle as frame_end belongs to this frame.
                    kp_count_d = wr_cnt_upd;
                    rd_addr_d  = '0;
                    wr_cnt_d   = '0;
                    state_d    = (wr_cnt_upd == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                rd_en     = 1'b1;
                kp_idx_d  = rd_addr_q;
                kp_last_d = ({1'b0, rd_addr_q} == (kp_count_q - (ADDR_W+1)'(1)));
                state_d   = SHOW;
            end
            SHOW: begin
                if (kp_if.kp_ready) begin
                    if (kp_last_q) begin
                        state_d = DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        state_d   = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            kp_count_q <= '0;
            wr_cnt_q   <= '0;
            ovf_q      <= 1'b0;
            kp_idx_q   <= '0;
            kp_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            kp_count_q <= kp_count_d;
            wr_cnt_q   <= wr_cnt_d;
            ovf_q      <= ovf_d;
            kp_idx_q   <= kp_idx_d;
            kp_last_q  <= kp_last_d;
        end
    end

    // Keypoint RAM with registered read; ram_q is the data register of the
    // presented keypoint and only changes in FETCH, so it is stable in SHOW.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[kp_if.num_fast[ADDR_W-1:0]] <= kp_if.XYO_fast;
        end
        if (rd_en) begin
            ram_q <= mem[rd_addr_q];
        end
    end

    // Keypoint fields are gated by SHOW so that reset forces them to zero
    // immediately, even though the RAM data register itself has no reset.
    logic show;
    assign show = (state_q == SHOW);

    assign kp_if.kp_valid = show;
    assign kp_if.kp_x     = show ? ram_q[XYO_W-1 -: 10] : '0;
    assign kp_if.kp_y     = show ? ram_q[11:2] : '0;
    assign kp_if.kp_o     = show ? ram_q[1:0] : '0;
    assign kp_if.kp_idx   = show ? kp_idx_q : '0;
    assign kp_if.kp_last  = show && kp_last_q;
    assign kp_if.rd_done  = (state_q == DONE);
    assign kp_if.kp_count = kp_count_q;
    assign kp_if.busy     = (state_q != IDLE);
    assign kp_if.ovf      = ovf_q;
endmodule

// File: tb/tb_fast_kp_reader.sv
// Self-checking bench for fast_kp_reader. A frame-level model (keypoint
// array, high-water count, expected beat queue, timing rules for latency and
// throughput) is checked against the DUT every falling edge; literal
// expectations from hand-decoded keypoints pin the model.
module tb_fast_kp_reader;
    localparam int AW    = 10;
    localparam int NW    = 14;
    localparam int XW    = 22;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fast_kp_reader_if #(.ADDR_W(AW), .NUM_W(NW), .XYO_W(XW)) bus ();

    fast_kp_reader #(.ADDR_W(AW), .NUM_W(NW), .XYO_W(XW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp_if (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int x;
        int y;
        int o;
        int idx;
        bit last;
    } beat_t;

    beat_t      exp_q[$];
    int         m_mem [DEPTH];
    int         m_wr_cnt = 0;
    int         m_count  = 0;
    bit         m_ovf    = 0;
    bit         done_due = 0;
    bit         done_nxt;
    bit         m_busy;
    bit         e_valid;
    int         next_valid_cyc = 0;
    int         cyc_n = 0;
    int         done_cnt = 0;
    bit         quiet = 0;

    logic [9:0] cap_x[$];
    logic [9:0] cap_y[$];
    logic [1:0] cap_o[$];
    int         cap_idx[$];
    bit         cap_last[$];

    always @(negedge clk) begin
        cyc_n++;
        if (!rst_n) begin
            chk("rst_valid", 32'(bus.kp_valid), 0);
            chk("rst_x", 32'(bus.kp_x), 0);
            chk("rst_last", 32'(bus.kp_last), 0);
            chk("rst_done", 32'(bus.rd_done), 0);
            chk("rst_count", 32'(bus.kp_count), 0);
            chk("rst_busy", 32'(bus.busy), 0);
            chk("rst_ovf", 32'(bus.ovf), 0);
            exp_q.delete();
            m_wr_cnt = 0;
            m_count  = 0;
            m_ovf    = 0;
            done_due = 0;
        end else begin
            m_busy  = (exp_q.size() != 0) || done_due;
            e_valid = (exp_q.size() != 0) && (cyc_n >= next_valid_cyc);
            chk("valid", 32'(bus.kp_valid), 32'(e_valid));
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("rd_done", 32'(bus.rd_done), 32'(done_due));
            chk("kp_count", 32'(bus.kp_count), 32'(m_count));
            chk("ovf", 32'(bus.ovf), 32'(m_ovf));
            if (bus.rd_done) done_cnt++;
            done_nxt = 0;
            if (e_valid && bus.kp_valid) begin
                chk("kp_x", 32'(bus.kp_x), 32'(exp_q[0].x));
                chk("kp_y", 32'(bus.kp_y), 32'(exp_q[0].y));
                chk("kp_o", 32'(bus.kp_o), 32'(exp_q[0].o));
                chk("kp_idx", 32'(bus.kp_idx), 32'(exp_q[0].idx));
                chk("kp_last", 32'(bus.kp_last), 32'(exp_q[0].last));
                if (bus.kp_ready) begin
                    cap_x.push_back(bus.kp_x);
                    cap_y.push_back(bus.kp_y);
                    cap_o.push_back(bus.kp_o);
                    cap_idx.push_back(int'(bus.kp_idx));
                    cap_last.push_back(bus.kp_last);
                    if (!quiet)
                        $display("beat idx=%0d x=%h y=%h o=%0d last=%0b",
                                 bus.kp_idx, bus.kp_x, bus.kp_y, bus.kp_o, bus.kp_last);
                    if (exp_q[0].last) done_nxt = 1;
                    void'(exp_q.pop_front());
                    next_valid_cyc = cyc_n + 2;
                end
            end
            // write side
            if (bus.wren_XYO_fast) begin
                if (m_busy || int'(bus.num_fast) >= DEPTH) begin
                    m_ovf = 1;
                end else begin
                    m_mem[int'(bus.num_fast)] = int'(bus.XYO_fast);
                    if (int'(bus.num_fast) + 1 > m_wr_cnt) m_wr_cnt = int'(bus.num_fast) + 1;
                end
            end
            if (bus.frame_end && !m_busy) begin
                m_count = m_wr_cnt;
                m_wr_cnt = 0;
                for (int i = 0; i < m_count; i++) begin
                    beat_t b;
                    b.x    = m_mem[i] / 4096;
                    b.y    = (m_mem[i] / 4) % 1024;
                    b.o    = m_mem[i] % 4;
                    b.idx  = i;
                    b.last = (i == m_count - 1);
                    exp_q.push_back(b);
                end
                if (m_count == 0) done_nxt = 1;
                next_valid_cyc = cyc_n + 2;
            end
            done_due = done_nxt;
        end
    end

    // ---------------- stimulus ----------------
    bit rand_ready = 0;
    int done_base  = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_ready) bus.kp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wr(input int idx, input logic [21:0] d);
        bus.wren_XYO_fast = 1'b1;
        bus.num_fast      = 14'(idx);
        bus.XYO_fast      = d;
        cyc();
        bus.wren_XYO_fast = 1'b0;
    endtask

    task automatic fe();
        done_base     = done_cnt;
        bus.frame_end = 1'b1;
        cyc();
        bus.frame_end = 1'b0;
    endtask

    task automatic wr_fe(input int idx, input logic [21:0] d);
        done_base         = done_cnt;
        bus.wren_XYO_fast = 1'b1;
        bus.num_fast      = 14'(idx);
        bus.XYO_fast      = d;
        bus.frame_end     = 1'b1;
        cyc();
        bus.wren_XYO_fast = 1'b0;
        bus.frame_end     = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (done_cnt == done_base && n < max_cyc) begin
            cyc();
            n++;
        end
        if (done_cnt == done_base) begin
            total++;
            bad++;
            $display("FAIL wait_done got=timeout exp=rd_done within %0d cycles", max_cyc);
        end
        cyc();
    endtask

    task automatic wait_valid(input int max_cyc);
        int n = 0;
        while (!bus.kp_valid && n < max_cyc) begin
            cyc();
            n++;
        end
        if (!bus.kp_valid) begin
            total++;
            bad++;
            $display("FAIL wait_valid got=timeout exp=kp_valid within %0d cycles", max_cyc);
        end
    endtask

    task automatic clear_caps();
        cap_x.delete();
        cap_y.delete();
        cap_o.delete();
        cap_idx.delete();
        cap_last.delete();
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.wren_XYO_fast = 1'b0;
        bus.num_fast      = '0;
        bus.XYO_fast      = '0;
        bus.frame_end     = 1'b0;
        bus.kp_ready      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        chk("init_busy", 32'(bus.busy), 0);
        chk("init_count", 32'(bus.kp_count), 0);

        // T1: three keypoints, ready held high
        clear_caps();
        bus.kp_ready = 1'b1;
        wr(0, 22'h12345C);
        wr(1, 22'h0ABC01);
        wr(2, 22'h3FFFFF);
        fe();
        chk("t1_count", 32'(bus.kp_count), 3);
        wait_done(50);
        chk("t1_beats", 32'(cap_x.size()), 3);
        chk("t1_x0", 32'(cap_x[0]), 32'h123);
        chk("t1_y0", 32'(cap_y[0]), 32'h117);
        chk("t1_o0", 32'(cap_o[0]), 0);
        chk("t1_x1", 32'(cap_x[1]), 32'h0AB);
        chk("t1_y1", 32'(cap_y[1]), 32'h300);
        chk("t1_o1", 32'(cap_o[1]), 1);
        chk("t1_x2", 32'(cap_x[2]), 32'h3FF);
        chk("t1_y2", 32'(cap_y[2]), 32'h3FF);
        chk("t1_o2", 32'(cap_o[2]), 3);
        chk("t1_last0", 32'(cap_last[0]), 0);
        chk("t1_last2", 32'(cap_last[2]), 1);

        // T2: same data, random ready, last write shares the frame_end cycle
        clear_caps();
        rand_ready = 1;
        wr(0, 22'h12345C);
        wr(1, 22'h0ABC01);
        wr_fe(2, 22'h3FFFFF);
        wait_done(200);
        rand_ready   = 0;
        bus.kp_ready = 1'b1;
        chk("t2_beats", 32'(cap_x.size()), 3);
        chk("t2_idx2", 32'(cap_idx[2]), 2);
        chk("t2_o2", 32'(cap_o[2]), 3);

        // T3: empty frame
        clear_caps();
        fe();
        wait_done(10);
        chk("t3_beats", 32'(cap_x.size()), 0);
        chk("t3_count", 32'(bus.kp_count), 0);

        // T4: out-of-range write, then a write during SHOW
        clear_caps();
        wr(DEPTH, 22'h155555);
        chk("t4_ovf", 32'(bus.ovf), 1);
        wr(0, 22'h2AAAAA);
        wr(1, 22'h1D2C47);
        bus.kp_ready = 1'b0;
        fe();
        wait_valid(10);
        wr(1, 22'h000000);
        bus.kp_ready = 1'b1;
        wait_done(50);
        chk("t4_beats", 32'(cap_x.size()), 2);
        chk("t4_x1", 32'(cap_x[1]), 32'h1D2);
        chk("t4_y1", 32'(cap_y[1]), 32'h311);
        chk("t4_ovf_sticky", 32'(bus.ovf), 1);

        // T5: full RAM
        clear_caps();
        quiet = 1;
        for (int i = 0; i < DEPTH; i++) begin
            logic [9:0] iv;
            iv = 10'(i);
            wr(i, {iv, ~iv, iv[1:0]});
        end
        fe();
        wait_valid(10);
        chk("t5_count", 32'(bus.kp_count), 1024);
        wait_done(3000);
        quiet = 0;
        $display("full-frame readout beats=%0d", cap_x.size());
        chk("t5_beats", 32'(cap_x.size()), 1024);
        chk("t5_idx_last", 32'(cap_idx[1023]), 1023);
        chk("t5_last", 32'(cap_last[1023]), 1);
        chk("t5_not_last", 32'(cap_last[1022]), 0);
        chk("t5_y500", 32'(cap_y[500]), 32'(10'h3FF - 10'd500));

        // T6: reset while beat 1 is presented
        clear_caps();
        bus.kp_ready = 1'b0;
        wr(0, 22'h12345C);
        wr(1, 22'h0ABC01);
        wr(2, 22'h3FFFFF);
        fe();
        wait_valid(10);
        bus.kp_ready = 1'b1;
        cyc();
        bus.kp_ready = 1'b0;
        wait_valid(10);
        chk("t6_idx_before", 32'(bus.kp_idx), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(bus.kp_valid), 0);
        chk("t6_x", 32'(bus.kp_x), 0);
        chk("t6_idx", 32'(bus.kp_idx), 0);
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_count", 32'(bus.kp_count), 0);
        chk("t6_ovf", 32'(bus.ovf), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        clear_caps();
        bus.kp_ready = 1'b1;
        wr(0, 22'h0ABC01);
        wr(1, 22'h12345C);
        fe();
        wait_done(50);
        chk("t6_beats", 32'(cap_x.size()), 2);
        chk("t6_x0", 32'(cap_x[0]), 32'h0AB);
        chk("t6_x1", 32'(cap_x[1]), 32'h123);
        chk("t6_last1", 32'(cap_last[1]), 1);

        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
